// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder, LSB-first, one bit pair per clock.
// A carry flop closes the Cout->Cin loop; sum bits shift into a result register.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             CarryIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             running;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    FullAdder1Bit u_fa (
        .A    (sha_q[0]),
        .B    (shb_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // Start only counts while not already working on an operation.
    assign accept   = Start && (state_q == S_IDLE || state_q == S_DONE);
    assign running  = (state_q == S_RUN);
    assign last_bit = running && (cnt_q == CNT_LAST);
    assign res_next = {fa_sum, res_q[WIDTH-1:1]};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = accept ? S_RUN : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        unique case (state_q)
            S_RUN:   Busy = 1'b1;
            S_DONE:  Done = 1'b1;
            default: begin
                Busy = 1'b0;
                Done = 1'b0;
            end
        endcase
    end

    always_comb begin
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            sha_d   = OpA;
            shb_d   = OpB;
            carry_d = CarryIn;
            cnt_d   = '0;
        end else if (running) begin
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            res_d   = res_next;
            carry_d = fa_cout;
            // Counter saturates at the last bit; no wrap state exists.
            cnt_d   = last_bit ? cnt_q : cnt_q + 1'b1;
            if (last_bit) begin
                sum_d  = res_next;
                cout_d = fa_cout;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

module FullAdder1Bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks for bit_serial_adder at WIDTH=8.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Start = 1'b0;
    logic [W-1:0] OpA = '0;
    logic [W-1:0] OpB = '0;
    logic         CarryIn = 1'b0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum;
    logic         Cout;

    int n_cmp = 0;
    int n_err = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Start   (Start),
        .OpA     (OpA),
        .OpB     (OpB),
        .CarryIn (CarryIn),
        .Busy    (Busy),
        .Done    (Done),
        .Sum     (Sum),
        .Cout    (Cout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called with the DUT in IDLE or DONE, #1 after an edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input string tag);
        int n;
        bit seen;
        logic [63:0] exp;
        exp = 64'(a) + 64'(b) + 64'(ci);
        OpA = a;
        OpB = b;
        CarryIn = ci;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        OpA = ~a;
        OpB = ~b;
        CarryIn = ~ci;
        chk({tag, ".busy"}, 64'(Busy), 64'd1);
        seen = 0;
        n = 0;
        while (!seen && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
            if (Done) seen = 1;
        end
        chk({tag, ".lat"}, 64'(n), 64'(W));
        chk({tag, ".res"}, 64'({Cout, Sum}), exp);
        chk({tag, ".busy_done"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        int pulses;
        int dc;
        int last;
        bit justdone;
        int acc;
        logic [W-1:0] v [3];
        logic [W-1:0] ra, rb;
        logic rc;

        #12;
        chk("rst.busy", 64'(Busy), 64'd0);
        chk("rst.done", 64'(Done), 64'd0);
        chk("rst.sum", 64'(Sum), 64'd0);
        chk("rst.cout", 64'(Cout), 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        run_op(8'h00, 8'h00, 1'b0, "t1");
        run_op(8'hFF, 8'h01, 1'b0, "t2");
        run_op(8'hA5, 8'h5A, 1'b1, "t3a");
        run_op(8'h7F, 8'h01, 1'b0, "t3b");

        // Start pulse during RUN must be ignored
        @(posedge Clk);
        #1;
        OpA = 8'h12;
        OpB = 8'h34;
        CarryIn = 1'b0;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Start = 1'b1;
        OpA = 8'h11;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                pulses++;
                chk("t4.res", 64'({Cout, Sum}), 64'h046);
            end
        end
        chk("t4.pulses", 64'(pulses), 64'd1);

        // Start held high: three back-to-back ops
        v[0] = 8'h01;
        v[1] = 8'h02;
        v[2] = 8'h03;
        OpA = v[0];
        OpB = v[0];
        CarryIn = 1'b0;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        OpA = v[1];
        OpB = v[1];
        acc = 1;
        dc = 0;
        last = 0;
        justdone = 0;
        for (int cyc = 1; cyc <= 40 && dc < 3; cyc++) begin
            @(posedge Clk);
            #1;
            if (justdone) begin
                justdone = 0;
                acc++;
                if (acc >= 3) begin
                    Start = 1'b0;
                end else begin
                    OpA = v[acc];
                    OpB = v[acc];
                end
            end
            if (Done) begin
                chk("t5.res", 64'({Cout, Sum}), 64'(2 * v[dc]));
                if (dc > 0) chk("t5.gap", 64'(cyc - last), 64'd9);
                last = cyc;
                dc++;
                justdone = 1;
            end
        end
        Start = 1'b0;
        chk("t5.count", 64'(dc), 64'd3);

        // Reset in mid-RUN aborts the op
        @(posedge Clk);
        #1;
        OpA = 8'h0F;
        OpB = 8'h01;
        CarryIn = 1'b0;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("t6.busy", 64'(Busy), 64'd0);
        chk("t6.done", 64'(Done), 64'd0);
        chk("t6.sum", 64'(Sum), 64'd0);
        chk("t6.cout", 64'(Cout), 64'd0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk);
            #1;
            if (Done || Busy) pulses++;
        end
        chk("t6.idle", 64'(pulses), 64'd0);
        run_op(8'h3C, 8'h0F, 1'b1, "t6.fresh");

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
